fixed_pair_accumulator: RTL and testbench

FIXED_PAIR_ACCUMULATOR -- requirements
Module: fixed_pair_accumulator

---
 rtl/fpam_pkg.sv | 19 +
 rtl/sat_add64.sv | 39 +++
 rtl/fixed_pair_accumulator.sv | 229 ++++++++++++++++++++++
 tb/tb_fixed_pair_accumulator.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpam_pkg.sv
// -----------------------------------------------------------------------------
// fpam_pkg
// Shared definitions for the fixed-point pair accumulator and the
// normalization stage that consumes its results.
//   FRAC_W       : width of the unsigned fraction format (window sums)
//   CNT_W        : width of the per-window sample count
//   fpam_state_e : accumulator control states
// -----------------------------------------------------------------------------
package fpam_pkg;

   localparam int FRAC_W = 64;
   localparam int CNT_W  = 16;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,   // accepting samples into the running window
      FULL  = 1'b1    // closed window parked in the accumulators, output busy
   } fpam_state_e;

endpackage

// File: rtl/sat_add64.sv
// -----------------------------------------------------------------------------
// sat_add64
// Adds one zero-extended IN_W-bit sample to a 64-bit running sum.
// Optional macro: SATURATE_EN -- clamp at 2^64-1 and report the overflow;
// without it the sum wraps modulo 2^64.
// Ports:
//   acc_i    : current running sum
//   sample_i : unsigned sample, zero-extended before the add
//   sum_o    : acc_i + sample_i (clamped or wrapped)
//   ovf_o    : (SATURATE_EN only) the true sum exceeded 2^64-1
// -----------------------------------------------------------------------------
module sat_add64
   import fpam_pkg::*;
#(
   parameter int IN_W = 32
) (
   input  logic [FRAC_W-1:0] acc_i,
   input  logic [IN_W-1:0]   sample_i,
   output logic [FRAC_W-1:0] sum_o
`ifdef SATURATE_EN
   ,
   output logic              ovf_o
`endif
);

`ifdef SATURATE_EN
   // One extra bit catches the carry out of the 64-bit add.
   logic [FRAC_W:0] wide_sum;

   always_comb begin
      wide_sum = {1'b0, acc_i} + (FRAC_W+1)'(sample_i);
      ovf_o    = wide_sum[FRAC_W];
      sum_o    = wide_sum[FRAC_W] ? '1 : wide_sum[FRAC_W-1:0];
   end
`else
   assign sum_o = acc_i + FRAC_W'(sample_i);
`endif

endmodule

// File: rtl/fixed_pair_accumulator.sv
// -----------------------------------------------------------------------------
// fixed_pair_accumulator
// Sums unsigned fixed-point samples on two channels (A, B) over windows of
// ACC_LEN samples (or fewer, when closed early by flush) and presents each
// window's pair of 64-bit sums plus its sample count through a valid/ready
// output slot. When a window closes while the slot is still occupied, the
// closed sums are parked in the accumulators (state FULL) and input stalls.
// Optional macro: SATURATE_EN -- sums clamp at 2^64-1 and a sticky per-window
// overflow flag is presented on out_ovf.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : sample handshake (in_ready is registered)
//   in_a, in_b           : unsigned samples, channels A and B
//   flush                : close the current non-empty window early
//   out_valid / out_ready: result handshake
//   out_a, out_b         : window sums (64-bit unsigned fraction)
//   out_cnt              : samples summed into the presented result
//   out_ovf              : (SATURATE_EN only) a sum saturated in this window
// -----------------------------------------------------------------------------
module fixed_pair_accumulator
   import fpam_pkg::*;
#(
   parameter int IN_W    = 32,
   parameter int ACC_LEN = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_a,
   input  logic [IN_W-1:0]   in_b,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [FRAC_W-1:0] out_a,
   output logic [FRAC_W-1:0] out_b,
   output logic [CNT_W-1:0]  out_cnt
`ifdef SATURATE_EN
   ,
   output logic              out_ovf
`endif
);

   localparam logic [CNT_W-1:0] ACC_LEN_C = CNT_W'(ACC_LEN);

   fpam_state_e       state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic [FRAC_W-1:0] acc_a_q, acc_a_d;
   logic [FRAC_W-1:0] acc_b_q, acc_b_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [FRAC_W-1:0] out_a_q, out_a_d;
   logic [FRAC_W-1:0] out_b_q, out_b_d;
   logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
`ifdef SATURATE_EN
   logic              ovf_q, ovf_d;
   logic              out_ovf_q, out_ovf_d;
   logic              ovf_a, ovf_b;
   logic              win_ovf;
`endif

   logic              accept;
   logic              out_xfer;
   logic              slot_free;
   logic              close;
   logic [FRAC_W-1:0] sum_a, sum_b;
   logic [FRAC_W-1:0] win_a, win_b;
   logic [CNT_W-1:0]  win_cnt;

   // ---------------------------------------------------------------- adders
   sat_add64 #(.IN_W(IN_W)) u_add_a (
      .acc_i    (acc_a_q),
      .sample_i (in_a),
      .sum_o    (sum_a)
`ifdef SATURATE_EN
      ,
      .ovf_o    (ovf_a)
`endif
   );

   sat_add64 #(.IN_W(IN_W)) u_add_b (
      .acc_i    (acc_b_q),
      .sample_i (in_b),
      .sum_o    (sum_b)
`ifdef SATURATE_EN
      ,
      .ovf_o    (ovf_b)
`endif
   );

   // in_ready_q is low in FULL, so no sample is taken there.
   assign accept    = in_valid && in_ready_q;
   assign out_xfer  = out_valid_q && out_ready;
   assign slot_free = !out_valid_q || out_ready;

   // Window contents including any sample accepted this cycle.
   assign win_a   = accept ? sum_a : acc_a_q;
   assign win_b   = accept ? sum_b : acc_b_q;
   assign win_cnt = cnt_q + CNT_W'(accept);
`ifdef SATURATE_EN
   assign win_ovf = ovf_q || (accept && (ovf_a || ovf_b));
`endif

   // ------------------------------------------------------ next-state logic
   always_comb begin
      // NOTE: every _d takes its hold value first, so no branch below can
      // leave a signal unassigned and infer a latch.
      state_d     = state_q;
      acc_a_d     = acc_a_q;
      acc_b_d     = acc_b_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      out_cnt_d   = out_cnt_q;
`ifdef SATURATE_EN
      ovf_d       = ovf_q;
      out_ovf_d   = out_ovf_q;
`endif
      close       = 1'b0;

      // A consumed result empties the slot unless a load below refills it.
      if (out_xfer) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         ACCUM: begin
            // flush on an empty window with no sample this cycle is a no-op.
            close = (accept && (win_cnt == ACC_LEN_C)) ||
                    (flush && (win_cnt != '0));
            if (close && slot_free) begin
               out_valid_d = 1'b1;
               out_a_d     = win_a;
               out_b_d     = win_b;
               out_cnt_d   = win_cnt;
               acc_a_d     = '0;
               acc_b_d     = '0;
               cnt_d       = '0;
`ifdef SATURATE_EN
               out_ovf_d   = win_ovf;
               ovf_d       = 1'b0;
`endif
            end else begin
               // Either still filling, or closed behind a busy slot: in both
               // cases the accumulators keep the window.
               acc_a_d = win_a;
               acc_b_d = win_b;
               cnt_d   = win_cnt;
`ifdef SATURATE_EN
               ovf_d   = win_ovf;
`endif
               if (close) begin
                  state_d = FULL;
               end
            end
         end

         FULL: begin
            // The parked window moves out the same cycle the slot drains, so
            // out_valid stays high across the hand-over.
            if (out_xfer) begin
               out_valid_d = 1'b1;
               out_a_d     = acc_a_q;
               out_b_d     = acc_b_q;
               out_cnt_d   = cnt_q;
               acc_a_d     = '0;
               acc_b_d     = '0;
               cnt_d       = '0;
`ifdef SATURATE_EN
               out_ovf_d   = ovf_q;
               ovf_d       = 1'b0;
`endif
               state_d     = ACCUM;
            end
         end
      endcase

      // Registered ready: it reflects the state being entered.
      in_ready_d = (state_d == ACCUM);
   end

   // ------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      if (rst) begin
         // NOTE: the data registers are reset too, because a reset must
         // discard partial and parked sums and present zeros, not stale data.
         state_q     <= ACCUM;
         in_ready_q  <= 1'b1;
         acc_a_q     <= '0;
         acc_b_q     <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         out_cnt_q   <= '0;
`ifdef SATURATE_EN
         ovf_q       <= 1'b0;
         out_ovf_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         acc_a_q     <= acc_a_d;
         acc_b_q     <= acc_b_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         out_cnt_q   <= out_cnt_d;
`ifdef SATURATE_EN
         ovf_q       <= ovf_d;
         out_ovf_q   <= out_ovf_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign out_cnt   = out_cnt_q;
`ifdef SATURATE_EN
   assign out_ovf   = out_ovf_q;
`endif

endmodule

// File: tb/tb_fixed_pair_accumulator.sv
// -----------------------------------------------------------------------------
// tb_fixed_pair_accumulator
// Directed scenarios followed by randomized handshake traffic for
// fixed_pair_accumulator (ACC_LEN=4, IN_W=32). A second instance with
// IN_W=64 reaches the top of the 64-bit range to exercise wrap/saturation.
// Honors SATURATE_EN to match the build of the design.
// -----------------------------------------------------------------------------
module tb_fixed_pair_accumulator;

   localparam int LEN = 4;

   logic        clk = 1'b0;
   logic        rst;

   // main instance, IN_W=32
   logic        in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_a, in_b;
   logic [63:0] out_a, out_b;
   logic [15:0] out_cnt;
   logic        out_ovf;

   // wide instance, IN_W=64
   logic        w_in_valid, w_in_ready, w_flush, w_out_valid, w_out_ready;
   logic [63:0] w_in_a, w_in_b;
   logic [63:0] w_out_a, w_out_b;
   logic [15:0] w_out_cnt;
   logic        w_out_ovf;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fixed_pair_accumulator #(.IN_W(32), .ACC_LEN(LEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_cnt   (out_cnt)
`ifdef SATURATE_EN
      ,
      .out_ovf   (out_ovf)
`endif
   );

   fixed_pair_accumulator #(.IN_W(64), .ACC_LEN(LEN)) dut_w (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (w_in_valid),
      .in_ready  (w_in_ready),
      .in_a      (w_in_a),
      .in_b      (w_in_b),
      .flush     (w_flush),
      .out_valid (w_out_valid),
      .out_ready (w_out_ready),
      .out_a     (w_out_a),
      .out_b     (w_out_b),
      .out_cnt   (w_out_cnt)
`ifdef SATURATE_EN
      ,
      .out_ovf   (w_out_ovf)
`endif
   );

`ifndef SATURATE_EN
   assign out_ovf   = 1'b0;
   assign w_out_ovf = 1'b0;
`endif

   task automatic check(input string tag, input logic [63:0] observed,
                        input logic [63:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------- reference model
   // A window is a run of accepted samples; it ends at LEN samples or at a
   // flush (seen while inputs are being taken) once it holds any sample.
   logic [63:0] exp_a_q[$];
   logic [63:0] exp_b_q[$];
   int          exp_cnt_q[$];
   bit          exp_ovf_q[$];
   logic [63:0] m_a, m_b;
   int          m_cnt;
   bit          m_ovf;
   int          emitted;
   bit          hold_pending;
   logic [63:0] hold_a, hold_b;
   logic [15:0] hold_cnt;

   function automatic logic [63:0] model_add(input logic [63:0] base,
                                             input logic [63:0] sample,
                                             inout bit ovf);
      logic [64:0] full;
      full = {1'b0, base} + {1'b0, sample};
`ifdef SATURATE_EN
      if (full[64]) begin
         ovf = 1'b1;
         return 64'hFFFF_FFFF_FFFF_FFFF;
      end
`endif
      return full[63:0];
   endfunction

   // Called with this cycle's inputs applied, before the clock edge.
   task automatic observe();
      logic [63:0] ea, eb;
      int          ec;
      bit          eo;
      if (hold_pending) begin
         check("hold_valid", out_valid, 1);
         check("hold_a", out_a, hold_a);
         check("hold_b", out_b, hold_b);
         check("hold_cnt", out_cnt, hold_cnt);
      end
      hold_pending = out_valid && !out_ready;
      hold_a = out_a; hold_b = out_b; hold_cnt = out_cnt;

      if (out_valid && out_ready) begin
         if (exp_a_q.size() == 0) begin
            check("rand_unexpected_result", out_valid, 0);
         end else begin
            ea = exp_a_q.pop_front();
            eb = exp_b_q.pop_front();
            ec = exp_cnt_q.pop_front();
            eo = exp_ovf_q.pop_front();
            check("rand_out_a", out_a, ea);
            check("rand_out_b", out_b, eb);
            check("rand_out_cnt", out_cnt, 64'(ec));
`ifdef SATURATE_EN
            check("rand_out_ovf", out_ovf, eo);
`endif
            emitted++;
         end
      end

      if (in_ready) begin
         if (in_valid) begin
            m_a = model_add(m_a, 64'(in_a), m_ovf);
            m_b = model_add(m_b, 64'(in_b), m_ovf);
            m_cnt++;
         end
         if ((in_valid && m_cnt == LEN) || (flush && m_cnt > 0)) begin
            exp_a_q.push_back(m_a);
            exp_b_q.push_back(m_b);
            exp_cnt_q.push_back(m_cnt);
            exp_ovf_q.push_back(m_ovf);
            m_a = '0; m_b = '0; m_cnt = 0; m_ovf = 1'b0;
         end
      end
   endtask

   // ----------------------------------------------------------------- stimulus
   initial begin
      rst = 1'b1;
      in_valid = 0; in_a = 0; in_b = 0; flush = 0; out_ready = 0;
      w_in_valid = 0; w_in_a = 0; w_in_b = 0; w_flush = 0; w_out_ready = 0;
      tick(); tick();
      rst = 1'b0;

      // reset state
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_a", out_a, 0);
      check("rst_out_b", out_b, 0);
      check("rst_out_cnt", out_cnt, 0);
      check("rst_out_ovf", out_ovf, 0);

      // two back-to-back windows, ready held high: 1..4 then 5..8
      out_ready = 1;
      for (int k = 1; k <= 8; k++) begin
         in_valid = 1; in_a = 32'(k); in_b = 32'h10;
         tick();
         check("b2b_in_ready", in_ready, 1);
         if (k == 3) check("w1_not_yet", out_valid, 0);
         if (k == 4) begin
            check("w1_valid", out_valid, 1);
            check("w1_out_a", out_a, 10);
            check("w1_out_b", out_b, 64'h40);
            check("w1_out_cnt", out_cnt, 4);
         end
         if (k == 5) check("w1_one_cycle", out_valid, 0);
      end
      check("w2_valid", out_valid, 1);
      check("w2_out_a", out_a, 26);
      in_valid = 0;
      tick();
      check("w2_drop", out_valid, 0);

      // backpressure: 8 samples offered with out_ready low, channel B = index
      out_ready = 0;
      for (int k = 1; k <= 8; k++) begin
         in_valid = 1; in_a = 1; in_b = 32'(k);
         tick();
      end
      check("full_in_ready", in_ready, 0);
      check("full_out_a", out_a, 4);
      check("full_out_b", out_b, 10);
      in_b = 99;                       // offered while FULL: must be ignored
      flush = 1;
      tick();
      flush = 0;
      check("full_stall_ready", in_ready, 0);
      check("full_stable_a", out_a, 4);
      check("full_stable_b", out_b, 10);
      in_valid = 0; out_ready = 1;
      tick();
      check("full_2nd_valid", out_valid, 1);
      check("full_2nd_a", out_a, 4);
      check("full_2nd_b", out_b, 26);
      check("full_2nd_cnt", out_cnt, 4);
      check("full_ready_back", in_ready, 1);
      tick();
      check("full_drain", out_valid, 0);

      // flush closes short windows; empty flush is ignored
      in_valid = 1; in_a = 5; in_b = 0; tick();
      in_a = 7; tick();
      in_valid = 0; flush = 1; tick();
      flush = 0;
      check("flush_valid", out_valid, 1);
      check("flush_out_a", out_a, 12);
      check("flush_out_cnt", out_cnt, 2);
      tick();
      check("flush_drop", out_valid, 0);
      flush = 1; tick();
      check("flush_empty_1", out_valid, 0);
      tick();
      check("flush_empty_2", out_valid, 0);
      in_valid = 1; in_a = 6; tick();      // sample and flush together, cnt 0
      in_valid = 0; flush = 0;
      check("flush_same_a", out_a, 6);
      check("flush_same_cnt", out_cnt, 1);
      tick();

      // reset mid-window discards partial sums, overrides the handshake
      for (int k = 0; k < 3; k++) begin
         in_valid = 1; in_a = 1; tick();
      end
      rst = 1; in_a = 100; tick();
      rst = 0; in_valid = 0;
      check("midrst_valid", out_valid, 0);
      check("midrst_ready", in_ready, 1);
      for (int k = 0; k < 4; k++) begin
         in_valid = 1; in_a = 1; tick();
      end
      in_valid = 0;
      check("midrst_out_a", out_a, 4);
      check("midrst_out_cnt", out_cnt, 4);
      tick();

      // reset while FULL discards held sums
      out_ready = 0;
      for (int k = 0; k < 8; k++) begin
         in_valid = 1; in_a = 1; tick();
      end
      check("rstfull_pre", in_ready, 0);
      rst = 1; out_ready = 1; tick();
      rst = 0; in_valid = 0;
      check("rstfull_valid", out_valid, 0);
      check("rstfull_ready", in_ready, 1);
      check("rstfull_out_a", out_a, 0);
      tick();
      check("rstfull_no_held", out_valid, 0);

      // top of the 64-bit range: (2^64-2) + 5
      w_out_ready = 1; w_in_valid = 1; w_in_b = 0;
      w_in_a = 64'hFFFF_FFFF_FFFF_FFFE; tick();
      w_in_a = 5; tick();
      w_in_a = 0; tick();
      tick();
      w_in_valid = 0;
      check("top_valid", w_out_valid, 1);
`ifdef SATURATE_EN
      check("top_out_a", w_out_a, 64'hFFFF_FFFF_FFFF_FFFF);
      check("top_ovf", w_out_ovf, 1);
`else
      check("top_out_a", w_out_a, 3);
`endif
      w_in_valid = 1; w_in_a = 1;
      for (int k = 0; k < 4; k++) tick();
      w_in_valid = 0;
      check("top_next_a", w_out_a, 4);
      check("top_next_ovf", w_out_ovf, 0);

      // randomized traffic against the window model
      m_a = '0; m_b = '0; m_cnt = 0; m_ovf = 0; emitted = 0;
      hold_pending = 0;
      in_valid = 0; flush = 0; out_ready = 1;
      tick(); tick();                   // drain anything still presented
      for (int cyc = 0; cyc < 60000 && emitted < 1000; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_a      = $urandom;
         in_b      = $urandom;
         flush     = ($urandom_range(0, 19) == 0);
         out_ready = ($urandom_range(0, 4) < 3);
         observe();
         tick();
      end
      check("rand_windows", 64'(emitted), 1000);
      for (int cyc = 0; cyc < 8; cyc++) begin
         in_valid = 0; out_ready = 1; flush = (cyc < 5);
         observe();
         tick();
      end
      check("rand_none_dropped", 64'(exp_a_q.size()), 0);
      check("rand_idle", out_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
